mux_capture_stage: RTL and testbench

Downstream consumer of the 2:1 safe-select mux. It registers the mux output `y` and the `sel_unknown` flag into a small valid/ready FIFO, and discards every beat captured while the select was unknown. It counts those discarded beats, and enters a sticky FAULT state after a run of consecutive unknown-select beats. Downstream logic therefore only ever sees data that came from a known select value.

---
 rtl/mux_stage_pkg.sv | 17 +
 rtl/sync_fifo.sv | 79 +++++++
 rtl/mux_capture_stage.sv | 116 +++++++++++
 tb/tb_mux_capture_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stage_pkg.sv
// Shared types and default parameters for the mux capture stage.
package mux_stage_pkg;

  // Operating state of the capture stage.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W       = 8;
  localparam int DEFAULT_ERR_W        = 8;
  localparam int DEFAULT_FAULT_THRESH = 3;

  // Wide enough to count up to the largest legal FAULT_THRESH (255).
  localparam int CONSEC_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and occupancy count.
// The head entry is read straight from storage, so the output is decoded
// from registers only. Writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Qualify requests against occupancy so the pointers can never overrun.
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
  end

  // Pointer and occupancy next-state; DEPTH is a power of two so the
  // pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero straight away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Status and head data decoded from registers.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
  end

endmodule

// File: rtl/mux_capture_stage.sv
// Capture stage behind the 2:1 safe-select mux. Good beats go into a small
// FIFO; beats captured while the select was unknown are dropped and counted.
// A run of FAULT_THRESH consecutive dropped beats latches FAULT, which
// blocks further input until fault_clr.
//
// Handshake: a beat transfers on a rising edge where valid && ready. Ready
// never depends on the partner's valid, and in_ready is decoded purely from
// registered state (no path from out_ready).
module mux_capture_stage
  import mux_stage_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DEPTH        = 2,
  parameter int ERR_W        = DEFAULT_ERR_W,
  parameter int FAULT_THRESH = DEFAULT_FAULT_THRESH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel_unknown,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fault,
  input  logic              fault_clr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t                state_q, state_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;

  logic                  accept, bad, pop, push;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  // An X or Z on the flag is treated as unknown, hence the case inequality.
  always_comb begin
    bad    = (in_sel_unknown !== 1'b0);
    accept = in_valid && in_ready;
    push   = accept && !bad;
    pop    = out_valid && out_ready;
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Error counters: the clear applies first, so a bad beat in the same
  // cycle as fault_clr is counted on top of the cleared value.
  always_comb begin
    err_d    = fault_clr ? '0 : err_q;
    consec_d = fault_clr ? '0 : consec_q;
    if (accept) begin
      if (bad) begin
        if (err_d != '1)    err_d    = err_d + ERR_W'(1);
        if (consec_d != '1) consec_d = consec_d + CONSEC_W'(1);
      end else begin
        consec_d = '0;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= '0;
      consec_q <= '0;
    end else begin
      err_q    <= err_d;
      consec_q <= consec_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: clear returns to RUN, then a threshold-reaching bad
  // beat (only possible in RUN) moves to FAULT on the same edge.
  always_comb begin
    state_d = state_q;
    if (fault_clr) state_d = ST_RUN;
    if (accept && bad && (consec_d >= CONSEC_W'(FAULT_THRESH))) state_d = ST_FAULT;
  end

  // FSM outputs, all decoded from registers.
  always_comb begin
    in_ready  = (state_q == ST_RUN) && !fifo_full;
    fault     = (state_q == ST_FAULT);
    out_valid = !fifo_empty;
    err_cnt   = err_q;
  end

  // Occupancy must stay within range and agree with the full flag.
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_count <= CNT_W'(DEPTH)) && (fifo_full == (fifo_count == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_mux_capture_stage.sv
// Self-checking bench for mux_capture_stage: directed scenarios plus a
// randomized run, all checked against a queue-based reference model.
module tb_mux_capture_stage;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int ERR_W  = 8;
  localparam int THRESH = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel_unknown;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ERR_W-1:0]  err_cnt;
  logic              fault;
  logic              fault_clr;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents as a queue plus plain integer counters.
  logic [DATA_W-1:0] exp_q[$];
  int                m_err;
  int                m_consec;
  bit                m_fault;

  mux_capture_stage #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .ERR_W        (ERR_W),
    .FAULT_THRESH (THRESH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sel_unknown (in_sel_unknown),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .err_cnt        (err_cnt),
    .fault          (fault),
    .fault_clr      (fault_clr)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    exp_q.delete();
    m_err    = 0;
    m_consec = 0;
    m_fault  = 0;
  endtask

  // Driver: inputs are already set (at a falling edge); advance one rising
  // edge, update the model from the same inputs, return at the next falling edge.
  task automatic tick();
    int sz;
    bit rdy, acc, bad, popb;
    sz   = exp_q.size();
    rdy  = (sz < DEPTH) && !m_fault;
    acc  = in_valid && rdy;
    bad  = (in_sel_unknown !== 1'b0);
    popb = (sz > 0) && out_ready;
    @(posedge clk);
    if (popb) void'(exp_q.pop_front());
    if (fault_clr) begin
      m_err = 0; m_consec = 0; m_fault = 0;
    end
    if (acc) begin
      if (bad) begin
        if (m_err < 255) m_err++;
        m_consec++;
        if (m_consec >= THRESH) m_fault = 1;
      end else begin
        exp_q.push_back(in_data);
        m_consec = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic unk,
                       input bit ordy, input bit clr);
    in_valid = v; in_data = d; in_sel_unknown = unk; out_ready = ordy; fault_clr = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 1'b0, 0, 0);
    #3;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL reset out_data got=%h exp=00", out_data); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset err_cnt got=%h exp=00", err_cnt); end
    if (fault !== 1'b0) begin failures++; $display("FAIL reset fault got=%b exp=0", fault); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pass_through();
    logic [DATA_W-1:0] pat [2];
    pat[0] = 8'hA5; pat[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      drive(1, pat[i], 1'b0, 1, 0);
      tick();
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL pass out_valid beat=%0d got=%b exp=1", i, out_valid); end
      if (out_data !== pat[i]) begin failures++; $display("FAIL pass out_data beat=%0d got=%h exp=%h", i, out_data, pat[i]); end
    end
    drive(0, 8'h00, 1'b0, 1, 0);
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL pass drained out_valid got=%b exp=0", out_valid); end
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL pass err_cnt got=%h exp=00", err_cnt); end
  endtask

  task automatic test_backpressure();
    drive(1, 8'h01, 1'b0, 0, 0); tick();
    drive(1, 8'h02, 1'b0, 0, 0); tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp in_ready_full got=%b exp=0", in_ready); end
    drive(1, 8'h03, 1'b0, 0, 0); tick();
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp in_ready_held got=%b exp=0", in_ready); end
    if (out_data !== 8'h01) begin failures++; $display("FAIL bp head got=%h exp=01", out_data); end
    drive(1, 8'h03, 1'b0, 1, 0); tick();
    checks++;
    if (out_data !== 8'h02) begin failures++; $display("FAIL bp drain1 got=%h exp=02", out_data); end
    drive(1, 8'h03, 1'b0, 1, 0); tick();
    checks += 2;
    if (out_data !== 8'h03) begin failures++; $display("FAIL bp third got=%h exp=03", out_data); end
    if (exp_q.size() != 1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp third_valid got=%b exp=1", out_valid); end
    drive(0, 8'h00, 1'b0, 1, 0); tick();
  endtask

  task automatic test_discard();
    drive(1, 8'h11, 1'b0, 1, 0); tick();
    checks++;
    if (out_data !== 8'h11 || out_valid !== 1'b1) begin failures++; $display("FAIL discard first got=%h/%b exp=11/1", out_data, out_valid); end
    drive(1, 8'h22, 1'b1, 1, 0); tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL discard dropped out_valid got=%b exp=0", out_valid); end
    drive(1, 8'h33, 1'b0, 1, 0); tick();
    checks += 3;
    if (out_data !== 8'h33 || out_valid !== 1'b1) begin failures++; $display("FAIL discard third got=%h/%b exp=33/1", out_data, out_valid); end
    if (err_cnt !== 8'd1) begin failures++; $display("FAIL discard err_cnt got=%0d exp=1", err_cnt); end
    if (fault !== 1'b0) begin failures++; $display("FAIL discard fault got=%b exp=0", fault); end
    drive(0, 8'h00, 1'b0, 1, 0); tick();
  endtask

  task automatic test_x_flag();
    logic [ERR_W-1:0] e;
    drive(1, 8'h44, 1'b0, 0, 0); tick();
    for (int i = 0; i < THRESH; i++) begin
      drive(1, 8'h55 + 8'(i), 1'bx, 0, 0); tick();
    end
    drive(0, 8'h00, 1'b0, 0, 0);
    e = ERR_W'(m_err);
    checks += 4;
    if (err_cnt !== e) begin failures++; $display("FAIL xflag err_cnt got=%0d exp=%0d", err_cnt, e); end
    if (fault !== m_fault) begin failures++; $display("FAIL xflag fault got=%b exp=%b", fault, m_fault); end
    if (in_ready !== (exp_q.size() < DEPTH && !m_fault)) begin failures++; $display("FAIL xflag in_ready got=%b", in_ready); end
    if (out_data !== 8'h44 || out_valid !== 1'b1) begin failures++; $display("FAIL xflag head got=%h/%b exp=44/1", out_data, out_valid); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'h00, 1'b0, 1, 0); tick();
    end
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL xflag drained out_valid got=%b exp=0", out_valid); end
    if (fault !== m_fault) begin failures++; $display("FAIL xflag fault_after_drain got=%b exp=%b", fault, m_fault); end
  endtask

  task automatic test_clear();
    drive(0, 8'h00, 1'b0, 1, 1); tick();
    checks += 3;
    if (fault !== 1'b0) begin failures++; $display("FAIL clear fault got=%b exp=0", fault); end
    if (err_cnt !== 8'd0) begin failures++; $display("FAIL clear err_cnt got=%0d exp=0", err_cnt); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL clear in_ready got=%b exp=1", in_ready); end
    drive(1, 8'h66, 1'b1, 1, 1); tick();
    checks += 2;
    if (err_cnt !== 8'd1) begin failures++; $display("FAIL clear_with_bad err_cnt got=%0d exp=1", err_cnt); end
    if (fault !== 1'b0) begin failures++; $display("FAIL clear_with_bad fault got=%b exp=0", fault); end
    drive(1, 8'h77, 1'b0, 1, 0); tick();
    drive(0, 8'h00, 1'b0, 1, 0); tick();
  endtask

  task automatic test_random();
    logic [ERR_W-1:0] e;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, DATA_W'($urandom), logic'($urandom_range(0, 3) == 0),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick();
      e = ERR_W'(m_err);
      checks += 4;
      if (out_valid !== (exp_q.size() > 0)) begin failures++; $display("FAIL rand out_valid cyc=%0d got=%b exp=%b", c, out_valid, exp_q.size() > 0); end
      if (in_ready !== (exp_q.size() < DEPTH && !m_fault)) begin failures++; $display("FAIL rand in_ready cyc=%0d got=%b", c, in_ready); end
      if (err_cnt !== e) begin failures++; $display("FAIL rand err_cnt cyc=%0d got=%0d exp=%0d", c, err_cnt, e); end
      if (fault !== m_fault) begin failures++; $display("FAIL rand fault cyc=%0d got=%b exp=%b", c, fault, m_fault); end
      if (exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin failures++; $display("FAIL rand out_data cyc=%0d got=%h exp=%h", c, out_data, exp_q[0]); end
      end
    end
    drive(0, 8'h00, 1'b0, 0, 0);
  endtask

  task automatic test_mid_reset();
    logic [ERR_W-1:0] e;
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(0, 8'h00, 1'b0, 1, 1); tick();
    end
    drive(1, 8'h99, 1'b1, 0, 0); tick();
    drive(1, 8'hB1, 1'b0, 0, 0); tick();
    drive(1, 8'hB2, 1'b0, 0, 0); tick();
    drive(0, 8'h00, 1'b0, 0, 0);
    e = ERR_W'(m_err);
    checks += 3;
    if (out_valid !== 1'b1 || out_data !== 8'hB1) begin failures++; $display("FAIL midrst pre head got=%h/%b exp=b1/1", out_data, out_valid); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst pre in_ready got=%b exp=0", in_ready); end
    if (err_cnt !== e) begin failures++; $display("FAIL midrst pre err_cnt got=%0d exp=%0d", err_cnt, e); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst out_valid got=%b exp=0", out_valid); end
    if (out_data !== 8'h00) begin failures++; $display("FAIL midrst out_data got=%h exp=00", out_data); end
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL midrst err_cnt got=%0d exp=0", err_cnt); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 8'h00, 1'b0, 1, 0); tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst post out_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    drive(0, 8'h00, 1'b0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_backpressure();
    test_discard();
    test_x_flag();
    test_clear();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
